// File: rtl/scoreboard_digit_demux.sv
// Score digit demux: frames of 1..4 BCD digits fill a shadow bank that is committed
// atomically to D0..D3, plus a free-running one-hot scan. Option: SCOREBOARD_LEADING_BLANK_EN.
module scoreboard_digit_demux #(
   parameter int          REFRESH_DIV = 50000,
   parameter logic [3:0]  BLANK       = 4'hF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [3:0] in_digit_i,
   input  logic       in_last_i,
   output logic [3:0] d0_o,
   output logic [3:0] d1_o,
   output logic [3:0] d2_o,
   output logic [3:0] d3_o,
   output logic [3:0] code_o,
   output logic       frame_done_o
);

   localparam int NUM_DIGITS = 4;
   localparam int CW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic {FILL, COMMIT} state_t;

   state_t                           state_q, state_d;
   logic [NUM_DIGITS-1:0][3:0]       shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0][3:0]       digits_q, digits_d;
   logic [NUM_DIGITS-1:0][3:0]       commit_val;
   logic [1:0]                       wp_q, wp_d;
   logic                             frame_done_q, frame_done_d;
   logic [CW-1:0]                    div_cnt_q;
   logic [3:0]                       code_q;
   logic                             accept;

   assign in_ready_o   = (state_q == FILL) && !rst_i;
   assign accept       = in_valid_i && in_ready_o;
   assign d0_o         = digits_q[0];
   assign d1_o         = digits_q[1];
   assign d2_o         = digits_q[2];
   assign d3_o         = digits_q[3];
   assign code_o       = code_q;
   assign frame_done_o = frame_done_q;

`ifdef SCOREBOARD_LEADING_BLANK_EN
   logic lead;
   // Walk from the most significant digit; unwritten (BLANK) digits count as leading.
   always_comb begin
      commit_val = shadow_q;
      lead       = 1'b1;
      for (int i = NUM_DIGITS-1; i >= 1; i--) begin
         lead = lead && ((shadow_q[i] == 4'h0) || (shadow_q[i] == BLANK));
         if (lead) commit_val[i] = BLANK;
      end
   end
`else
   assign commit_val = shadow_q;
`endif

   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      digits_d     = digits_q;
      wp_d         = wp_q;
      frame_done_d = 1'b0;
      case (state_q)
         FILL: begin
            if (accept) begin
               shadow_d[wp_q] = in_digit_i;
               wp_d           = wp_q + 2'd1;
               if (in_last_i || (wp_q == 2'd3)) state_d = COMMIT;
            end
         end
         COMMIT: begin
            digits_d     = commit_val;
            shadow_d     = {NUM_DIGITS{BLANK}};
            wp_d         = 2'd0;
            frame_done_d = 1'b1;
            state_d      = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= FILL;
         shadow_q     <= {NUM_DIGITS{BLANK}};
         digits_q     <= '0;
         wp_q         <= 2'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         digits_q     <= digits_d;
         wp_q         <= wp_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Scan runs regardless of the frame FSM so the display refresh never stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt_q <= '0;
         code_q    <= 4'b0001;
      end else if (div_cnt_q == CW'(REFRESH_DIV-1)) begin
         div_cnt_q <= '0;
         code_q    <= {code_q[2:0], code_q[3]};
      end else begin
         div_cnt_q <= div_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_scoreboard_digit_demux.sv
// Directed bench for scoreboard_digit_demux: table of frames plus reset/scan sequences.
module tb_scoreboard_digit_demux;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_digit;
   logic       in_last;
   logic [3:0] d0, d1, d2, d3;
   logic [3:0] code;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   scoreboard_digit_demux #(.REFRESH_DIV(4), .BLANK(4'hF)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_digit_i(in_digit), .in_last_i(in_last),
      .d0_o(d0), .d1_o(d1), .d2_o(d2), .d3_o(d3),
      .code_o(code), .frame_done_o(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          n;
      bit          uselast;
      logic [15:0] dig;   // {digit3,digit2,digit1,digit0}, digit0 sent first
      logic [15:0] exp;   // {D3,D2,D1,D0}
      string       nm;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] dvec();
      return {d3, d2, d1, d0};
   endfunction

   task automatic send_frame(input int n, input bit uselast, input logic [15:0] dig,
                             input logic [15:0] exp, input string nm);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({nm, " ready"}, {15'd0, in_ready}, 16'd1);
         in_valid = 1'b1;
         in_digit = dig[i*4 +: 4];
         in_last  = uselast && (i == n-1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      chk({nm, " commit ready"}, {15'd0, in_ready}, 16'd0);
      chk({nm, " early done"}, {15'd0, frame_done}, 16'd0);
      @(negedge clk);
      chk({nm, " done"}, {15'd0, frame_done}, 16'd1);
      chk({nm, " digits"}, dvec(), exp);
      @(negedge clk);
      chk({nm, " done pulse"}, {15'd0, frame_done}, 16'd0);
      chk({nm, " hold"}, dvec(), exp);
      chk({nm, " ready after"}, {15'd0, in_ready}, 16'd1);
   endtask

   initial begin
      vecs[0] = '{4, 1'b0, 16'h1234, 16'h1234, "f4321"};
      vecs[1] = '{2, 1'b1, 16'h0057, 16'hFF57, "f75"};
      vecs[2] = '{4, 1'b1, 16'h9999, 16'h9999, "f9999"};
`ifdef SCOREBOARD_LEADING_BLANK_EN
      vecs[3] = '{4, 1'b1, 16'h0005, 16'hFFF5, "f5000"};
      vecs[4] = '{4, 1'b1, 16'h0000, 16'hFFF0, "f0000"};
`else
      vecs[3] = '{4, 1'b1, 16'h0005, 16'h0005, "f5000"};
      vecs[4] = '{4, 1'b1, 16'h0000, 16'h0000, "f0000"};
`endif
      vecs[5] = '{1, 1'b1, 16'h0003, 16'hFFF3, "f3"};
      vecs[6] = '{3, 1'b1, 16'h0700, 16'hF700, "f007"};
      vecs[7] = '{4, 1'b0, 16'h2001, 16'h2001, "f1002"};

      rst = 1'b1; in_valid = 1'b0; in_digit = 4'h0; in_last = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst ready", {15'd0, in_ready}, 16'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst digits", dvec(), 16'h0000);
      chk("rst code", {12'd0, code}, 16'h0001);
      chk("rst ready after", {15'd0, in_ready}, 16'd1);
      chk("rst done", {15'd0, frame_done}, 16'd0);

      foreach (vecs[i]) send_frame(vecs[i].n, vecs[i].uselast, vecs[i].dig, vecs[i].exp, vecs[i].nm);

      // Scan sequence with a commit in the middle
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("scan k%0d", k), {12'd0, code}, 16'(4'b0001 << ((k/4) % 4)));
         if (k == 4) begin
            in_valid = 1'b1; in_digit = 4'h6; in_last = 1'b1;
         end
         if (k == 5) begin
            in_valid = 1'b0; in_last = 1'b0;
            chk("scan commit ready", {15'd0, in_ready}, 16'd0);
         end
         if (k == 6) begin
            chk("scan commit done", {15'd0, frame_done}, 16'd1);
            chk("scan commit digits", dvec(), 16'hFFF6);
         end
      end

      // Reset mid-frame discards the partial shadow
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_digit = 4'(i + 1); in_last = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("midrst ready", {15'd0, in_ready}, 16'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst digits", dvec(), 16'h0000);
      chk("midrst code", {12'd0, code}, 16'h0001);
      send_frame(1, 1'b1, 16'h0008, 16'hFFF8, "f8");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
